pulse_param_ctrl: RTL and testbench

Runtime parameter controller for the `pulses` generator. It parses 5-byte write frames from the host byte receiver into shadow registers and computes the derived timing values. On a commit command it applies the whole parameter set atomically at the next period boundary, so the pulse sequence never mixes old and new settings within one period. It sits between the UART receiver and `pulses`, and replaces the static power-on parameter load.

---
 rtl/pulse_param_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_pulse_param_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_param_ctrl.sv
// pulse_param_ctrl: parses 5-byte host frames into shadow parameters and applies them atomically at a period boundary
module pulse_param_ctrl #(
    parameter logic [31:0] TIMEOUT   = 32'd50000,
    parameter logic [31:0] ST_PERIOD = 32'd20000,
    parameter logic [31:0] ST_P1     = 32'd30,
    parameter logic [31:0] ST_P2     = 32'd60,
    parameter logic [31:0] ST_DELAY  = 32'd200,
    parameter logic [31:0] ST_ATTDLY = 32'd2000,
    parameter logic [15:0] ST_OFFRES = 16'd500
) (
    input  logic        clk_pll,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        period_start,
    output logic [31:0] period,
    output logic [31:0] p1width,
    output logic [31:0] p2width,
    output logic [31:0] delay,
    output logic [31:0] pbwidth,
    output logic [31:0] p2start,
    output logic [31:0] sync_up,
    output logic [31:0] att_down,
    output logic [31:0] offres_delay,
    output logic        pump,
    output logic        double,
    output logic        block,
    output logic [7:0]  pulse_block,
    output logic [6:0]  pp_pump,
    output logic [6:0]  pp_probe,
    output logic [6:0]  post_att,
    output logic        pending,
    output logic        applied,
    output logic        cmd_err
);
    typedef struct packed {
        logic [31:0] period;
        logic [31:0] p1;
        logic [31:0] p2;
        logic [31:0] dly;
        logic [31:0] pbw;
        logic [31:0] attd;
        logic [15:0] offres;
        logic [2:0]  flags;
        logic [7:0]  pblock;
        logic [6:0]  pp_pump;
        logic [6:0]  pp_probe;
        logic [6:0]  post_att;
    } shadow_t;

    typedef enum logic [2:0] {IDLE, ADDR_OK, D1, D2, D3} pstate_t;
    typedef enum logic {RUN, ARMED} cstate_t;

    localparam shadow_t SH_RST = '{period: ST_PERIOD, p1: ST_P1, p2: ST_P2, dly: ST_DELAY,
                                   pbw: ST_P1, attd: ST_ATTDLY, offres: ST_OFFRES, flags: 3'b111,
                                   pblock: 8'd50, pp_pump: 7'd0, pp_probe: 7'h7f, post_att: 7'h7f};
    localparam logic [31:0] D_P2   = ST_P1 + ST_DELAY;
    localparam logic [31:0] D_SYNC = D_P2 + ST_P2;
    localparam logic [31:0] D_ATT  = D_SYNC + ST_ATTDLY;
    localparam logic [31:0] D_OFF  = ST_PERIOD - {16'b0, ST_OFFRES} - ST_P1;

    function automatic shadow_t upd(input shadow_t s, input logic en, input logic [7:0] a, input logic [31:0] v);
        upd = s;
        if (en) begin
            case (a)
                8'h01: upd.period = v;
                8'h02: upd.p1 = v;
                8'h03: upd.p2 = v;
                8'h04: upd.dly = v;
                8'h05: upd.pbw = v;
                8'h06: upd.attd = v;
                8'h07: upd.offres = v[15:0];
                8'h08: upd.flags = v[2:0];
                8'h09: upd.pblock = v[7:0];
                8'h0A: begin
                    upd.pp_pump  = v[6:0];
                    upd.pp_probe = v[14:8];
                    upd.post_att = v[22:16];
                end
                default: ;
            endcase
        end
    endfunction

    pstate_t     pst;
    cstate_t     cst;
    shadow_t     sh;
    logic [7:0]  addr;
    logic [23:0] acc;
    logic [31:0] gap;
    logic [31:0] fval;
    logic [31:0] hold_val;
    logic [7:0]  hold_addr;
    logic        hold_full;
    logic        settle;
    logic [31:0] dp2, dsync, datt, doff;
    logic        frame_done, addr_ok, is_commit, is_write, timeout;
    logic        apply, flush, run_wr, hold_wr, drop;

    // The fourth value byte, sampled while in D3, completes the frame
    assign frame_done = rx_valid && pst == D3;
    assign fval       = {acc, rx_data};
    assign addr_ok    = addr inside {[8'h01:8'h0A], 8'h0F};
    assign is_commit  = addr == 8'h0F;
    assign is_write   = addr_ok && !is_commit;
    assign timeout    = pst != IDLE && !rx_valid && gap == TIMEOUT - 32'd1;
    // A shadow write in the previous cycle leaves the derived registers one cycle stale
    assign apply      = cst == ARMED && period_start && !settle;
    assign flush      = cst == RUN && hold_full;
    assign run_wr     = frame_done && is_write && cst == RUN;
    assign hold_wr    = frame_done && is_write && cst == ARMED && !hold_full;
    assign drop       = frame_done && is_write && cst == ARMED && hold_full;

    // Frame parser: address byte, then four value bytes MSB first, with inter-byte timeout
    always_ff @(posedge clk_pll or negedge resetn) begin
        if (!resetn) begin
            pst     <= IDLE;
            addr    <= '0;
            acc     <= '0;
            gap     <= '0;
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= timeout || (frame_done && !addr_ok) || drop;
            gap     <= (pst == IDLE || rx_valid) ? '0 : gap + 32'd1;
            if (timeout) begin
                pst <= IDLE;
            end else if (rx_valid) begin
                pst <= pst == IDLE ? ADDR_OK : pst == ADDR_OK ? D1 : pst == D1 ? D2 : pst == D2 ? D3 : IDLE;
                if (pst == IDLE) addr <= rx_data;
                else acc <= {acc[15:0], rx_data};
            end
        end
    end

    // Shadow set, one-entry hold for writes arriving while armed, and the commit state
    always_ff @(posedge clk_pll or negedge resetn) begin
        if (!resetn) begin
            sh        <= SH_RST;
            cst       <= RUN;
            pending   <= 1'b0;
            hold_full <= 1'b0;
            hold_addr <= '0;
            hold_val  <= '0;
            settle    <= 1'b0;
        end else begin
            sh     <= upd(upd(sh, flush, hold_addr, hold_val), run_wr, addr, fval);
            settle <= flush || run_wr;
            if (hold_wr) begin
                hold_full <= 1'b1;
                hold_addr <= addr;
                hold_val  <= fval;
            end else if (flush) begin
                hold_full <= 1'b0;
            end
            if (apply) begin
                cst     <= RUN;
                pending <= 1'b0;
            end else if (frame_done && is_commit && cst == RUN) begin
                cst     <= ARMED;
                pending <= 1'b1;
            end
        end
    end

    // Derived timing values recomputed from the shadow every cycle
    always_ff @(posedge clk_pll or negedge resetn) begin
        if (!resetn) begin
            dp2   <= D_P2;
            dsync <= D_SYNC;
            datt  <= D_ATT;
            doff  <= D_OFF;
        end else begin
            dp2   <= sh.p1 + sh.dly;
            dsync <= sh.p1 + sh.dly + sh.p2;
            datt  <= sh.p1 + sh.dly + sh.p2 + sh.attd;
            doff  <= sh.period - {16'b0, sh.offres} - sh.p1;
        end
    end

    // Active set: loads the whole shadow at once on apply
    always_ff @(posedge clk_pll or negedge resetn) begin
        if (!resetn) begin
            period       <= ST_PERIOD;
            p1width      <= ST_P1;
            p2width      <= ST_P2;
            delay        <= ST_DELAY;
            pbwidth      <= ST_P1;
            p2start      <= D_P2;
            sync_up      <= D_SYNC;
            att_down     <= D_ATT;
            offres_delay <= D_OFF;
            {block, double, pump} <= 3'b111;
            pulse_block  <= 8'd50;
            pp_pump      <= 7'd0;
            pp_probe     <= 7'h7f;
            post_att     <= 7'h7f;
            applied      <= 1'b0;
        end else begin
            applied <= apply;
            if (apply) begin
                period       <= sh.period;
                p1width      <= sh.p1;
                p2width      <= sh.p2;
                delay        <= sh.dly;
                pbwidth      <= sh.pbw;
                p2start      <= dp2;
                sync_up      <= dsync;
                att_down     <= datt;
                offres_delay <= doff;
                {block, double, pump} <= sh.flags;
                pulse_block  <= sh.pblock;
                pp_pump      <= sh.pp_pump;
                pp_probe     <= sh.pp_probe;
                post_att     <= sh.post_att;
            end
        end
    end
endmodule

// File: tb/tb_pulse_param_ctrl.sv
// tb_pulse_param_ctrl: directed self-checking bench for pulse_param_ctrl
module tb_pulse_param_ctrl;
    localparam logic [31:0] TO = 32'd20;

    logic        clk_pll = 1'b0;
    logic        resetn = 1'b0;
    logic        rx_valid = 1'b0;
    logic        period_start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic [31:0] period, p1width, p2width, delay, pbwidth, p2start, sync_up, att_down, offres_delay;
    logic        pump, double, block, pending, applied, cmd_err;
    logic [7:0]  pulse_block;
    logic [6:0]  pp_pump, pp_probe, post_att;
    int checks = 0;
    int errors = 0;

    always #5 clk_pll = ~clk_pll;

    pulse_param_ctrl #(.TIMEOUT(TO)) dut (
        .clk_pll(clk_pll), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
        .period_start(period_start), .period(period), .p1width(p1width), .p2width(p2width),
        .delay(delay), .pbwidth(pbwidth), .p2start(p2start), .sync_up(sync_up),
        .att_down(att_down), .offres_delay(offres_delay), .pump(pump), .double(double),
        .block(block), .pulse_block(pulse_block), .pp_pump(pp_pump), .pp_probe(pp_probe),
        .post_att(post_att), .pending(pending), .applied(applied), .cmd_err(cmd_err)
    );

    task automatic tick();
        @(posedge clk_pll);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] v);
        send_byte(a);
        send_byte(v[31:24]);
        send_byte(v[23:16]);
        send_byte(v[15:8]);
        send_byte(v[7:0]);
    endtask

    task automatic pulse_ps();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (p2start !== 32'd230) begin errors++; $display("FAIL in_reset_p2start got %0d want 230", p2start); end
        resetn = 1'b1;
        tick();
        checks++; if (p2start !== 32'd230) begin errors++; $display("FAIL reset_p2start got %0d want 230", p2start); end
        checks++; if (sync_up !== 32'd290) begin errors++; $display("FAIL reset_sync_up got %0d want 290", sync_up); end
        checks++; if (att_down !== 32'd2290) begin errors++; $display("FAIL reset_att_down got %0d want 2290", att_down); end
        checks++; if (offres_delay !== 32'd19470) begin errors++; $display("FAIL reset_offres got %0d want 19470", offres_delay); end
        checks++; if (period !== 32'd20000) begin errors++; $display("FAIL reset_period got %0d want 20000", period); end
        checks++; if ({pump, double, block} !== 3'b111) begin errors++; $display("FAIL reset_flags got %b want 111", {pump, double, block}); end
        checks++; if (pulse_block !== 8'd50) begin errors++; $display("FAIL reset_pblock got %0d want 50", pulse_block); end
        checks++; if ({pp_pump, pp_probe, post_att} !== {7'h00, 7'h7f, 7'h7f}) begin errors++; $display("FAIL reset_att got %h want 0/7f/7f", {pp_pump, pp_probe, post_att}); end
        checks++; if ({pending, applied, cmd_err} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b want 000", {pending, applied, cmd_err}); end
    endtask

    task automatic test_write_commit();
        send_frame(8'h02, 32'd40);
        checks++; if (p1width !== 32'd30) begin errors++; $display("FAIL wc_shadow_only got %0d want 30", p1width); end
        send_frame(8'h0F, 32'd0);
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL wc_pending got %b want 1", pending); end
        repeat (3) tick();
        checks++; if (p1width !== 32'd30 || applied !== 1'b0) begin errors++; $display("FAIL wc_hold_until_ps got p1=%0d applied=%b want 30/0", p1width, applied); end
        pulse_ps();
        checks++; if (p1width !== 32'd40) begin errors++; $display("FAIL wc_p1width got %0d want 40", p1width); end
        checks++; if (p2start !== 32'd240) begin errors++; $display("FAIL wc_p2start got %0d want 240", p2start); end
        checks++; if (sync_up !== 32'd300) begin errors++; $display("FAIL wc_sync_up got %0d want 300", sync_up); end
        checks++; if (offres_delay !== 32'd19460) begin errors++; $display("FAIL wc_offres got %0d want 19460", offres_delay); end
        checks++; if (applied !== 1'b1 || pending !== 1'b0) begin errors++; $display("FAIL wc_applied got applied=%b pending=%b want 1/0", applied, pending); end
        tick();
        checks++; if (applied !== 1'b0) begin errors++; $display("FAIL wc_applied_pulse got %b want 0", applied); end
    endtask

    task automatic test_armed_write();
        send_frame(8'h0F, 32'd0);
        send_frame(8'h04, 32'd500);
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL aw_no_err got %b want 0", cmd_err); end
        pulse_ps();
        checks++; if (delay !== 32'd200 || p2start !== 32'd240) begin errors++; $display("FAIL aw_frozen got delay=%0d p2start=%0d want 200/240", delay, p2start); end
        send_frame(8'h0F, 32'd0);
        pulse_ps();
        checks++; if (delay !== 32'd500) begin errors++; $display("FAIL aw_delay got %0d want 500", delay); end
        checks++; if (p2start !== 32'd540) begin errors++; $display("FAIL aw_p2start got %0d want 540", p2start); end
        checks++; if (att_down !== 32'd2600) begin errors++; $display("FAIL aw_att_down got %0d want 2600", att_down); end
    endtask

    task automatic test_errors();
        send_frame(8'h33, 32'h12345678);
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL err_badaddr got %b want 1", cmd_err); end
        checks++; if (pending !== 1'b0 || period !== 32'd20000) begin errors++; $display("FAIL err_badaddr_noop got pending=%b period=%0d want 0/20000", pending, period); end
        tick();
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL err_pulse got %b want 0", cmd_err); end
        send_frame(8'h0F, 32'd0);
        send_frame(8'h01, 32'd1000);
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL err_first_hold got %b want 0", cmd_err); end
        send_frame(8'h01, 32'd2000);
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL err_hold_overflow got %b want 1", cmd_err); end
        send_frame(8'h0F, 32'd0);
        checks++; if (cmd_err !== 1'b0 || pending !== 1'b1) begin errors++; $display("FAIL err_commit_armed got err=%b pending=%b want 0/1", cmd_err, pending); end
        pulse_ps();
        checks++; if (applied !== 1'b1 || period !== 32'd20000) begin errors++; $display("FAIL err_apply_frozen got applied=%b period=%0d want 1/20000", applied, period); end
        send_frame(8'h0F, 32'd0);
        pulse_ps();
        checks++; if (period !== 32'd1000) begin errors++; $display("FAIL err_hold_flushed got %0d want 1000", period); end
        checks++; if (offres_delay !== 32'd460) begin errors++; $display("FAIL err_offres got %0d want 460", offres_delay); end
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        send_byte(8'h03);
        send_byte(8'h00);
        for (int i = 1; i <= TO + 10 && n == 0; i++) begin
            tick();
            if (cmd_err === 1'b1) n = i;
        end
        checks++; if (n !== int'(TO)) begin errors++; $display("FAIL to_latency got %0d want %0d", n, TO); end
        send_frame(8'h03, 32'd100);
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL to_clean_frame got %b want 0", cmd_err); end
        send_frame(8'h0F, 32'd0);
        pulse_ps();
        checks++; if (p2width !== 32'd100) begin errors++; $display("FAIL to_p2width got %0d want 100", p2width); end
        checks++; if (sync_up !== 32'd640) begin errors++; $display("FAIL to_sync_up got %0d want 640", sync_up); end
    endtask

    task automatic test_modes();
        send_frame(8'h08, 32'd2);
        send_frame(8'h09, 32'd7);
        send_frame(8'h0A, 32'h00152A05);
        send_frame(8'h05, 32'd45);
        send_frame(8'h06, 32'd10);
        send_frame(8'h07, 32'h00AB0064);
        send_frame(8'h0F, 32'd0);
        pulse_ps();
        checks++; if ({pump, double, block} !== 3'b010) begin errors++; $display("FAIL md_flags got %b want 010", {pump, double, block}); end
        checks++; if (pulse_block !== 8'd7) begin errors++; $display("FAIL md_pblock got %0d want 7", pulse_block); end
        checks++; if ({pp_pump, pp_probe, post_att} !== {7'h05, 7'h2A, 7'h15}) begin errors++; $display("FAIL md_att got %h want 05/2a/15", {pp_pump, pp_probe, post_att}); end
        checks++; if (pbwidth !== 32'd45) begin errors++; $display("FAIL md_pbwidth got %0d want 45", pbwidth); end
        checks++; if (att_down !== 32'd650) begin errors++; $display("FAIL md_att_down got %0d want 650", att_down); end
        checks++; if (offres_delay !== 32'd860) begin errors++; $display("FAIL md_offres got %0d want 860", offres_delay); end
    endtask

    task automatic test_async_reset();
        send_frame(8'h0F, 32'd0);
        send_frame(8'h02, 32'd77);
        send_frame(8'h02, 32'd88);
        checks++; if (cmd_err !== 1'b1 || pending !== 1'b1) begin errors++; $display("FAIL ar_setup got err=%b pending=%b want 1/1", cmd_err, pending); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (p1width !== 32'd30 || period !== 32'd20000) begin errors++; $display("FAIL ar_immediate got p1=%0d period=%0d want 30/20000", p1width, period); end
        checks++; if (pending !== 1'b0 || p2start !== 32'd230 || pump !== 1'b1) begin errors++; $display("FAIL ar_state got pending=%b p2start=%0d pump=%b want 0/230/1", pending, p2start, pump); end
        tick();
        resetn = 1'b1;
        tick();
        pulse_ps();
        checks++; if (applied !== 1'b0 || p1width !== 32'd30) begin errors++; $display("FAIL ar_no_apply got applied=%b p1=%0d want 0/30", applied, p1width); end
        send_frame(8'h0F, 32'd0);
        pulse_ps();
        checks++; if (applied !== 1'b1 || p1width !== 32'd30 || p2start !== 32'd230) begin errors++; $display("FAIL ar_hold_discarded got applied=%b p1=%0d p2start=%0d want 1/30/230", applied, p1width, p2start); end
    endtask

    initial begin
        test_reset();
        test_write_commit();
        test_armed_write();
        test_errors();
        test_timeout();
        test_modes();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
